soc_dmem_arb: RTL and testbench
===============================

Name: soc_dmem_arb

Overview:
- Two-master arbiter sharing the single-port SoC data RAM between the cpu6 load/store port (master 0) and the VGA scanout fetcher (master 1, read-only).
- Sits in soc_top between the core data bus, the VGA controller and the data RAM.
- Accepts at most one access per cycle.
- Returns read data one cycle after the grant, routed to the master that issued the read.
- Prevents CPU starvation under continuous VGA demand.

Parameters:
- AW, 32: address width (byte address; RAM is word-indexed by addr[AW-1:2]).
- DW, 32: data width.
- MAX_WAIT, 4: consecutive denied cycles of m0 before m0 is forced to win; range 1..15.

Ports:
- clk  in  1  system/cpu clock
- reset  in  1  synchronous, active-low reset
- m0_req  in  1  CPU access request; held with stable fields until m0_gnt
- m0_we  in  1  CPU write enable
- m0_addr  in  AW  CPU byte address
- m0_wdata  in  DW  CPU write data
- m0_wmask  in  DW/8  CPU byte write mask
- m0_gnt  out  1  CPU request accepted this cycle
- m0_rvalid  out  1  CPU read data valid
- m0_rdata  out  DW  CPU read data
- m1_req  in  1  VGA read request; held with stable address until m1_gnt
- m1_addr  in  AW  VGA byte address
- m1_gnt  out  1  VGA request accepted this cycle
- m1_rvalid  out  1  VGA read data valid
- m1_rdata  out  DW  VGA read data
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW-2  RAM word address
- ram_wdata  out  DW  RAM write data
- ram_wmask  out  DW/8  RAM byte mask
- ram_rdata  in  DW  RAM read data, valid one cycle after ram_en with ram_we=0

Behaviour:
Grant logic (combinational from req and registered state):
- At most one of m0_gnt/m1_gnt is high per cycle.
- A grant is never given without the matching req.
- Only m0 requesting: m0 granted. Only m1 requesting: m1 granted.
- Both requesting, default policy is fixed priority m1 (pixel fetch is latency-critical), except:
  - when wait_cnt == MAX_WAIT, m0 wins.

RAM drive:
- ram_en = m0_gnt | m1_gnt.
- ram_addr, ram_we, ram_wdata and ram_wmask are muxed from the granted master in the same cycle.
- With m1 granted: ram_we=0, ram_wmask=0.
- With no grant: ram_we=0; address/data are don't-care, but are driven 0.

wait_cnt:
- 4-bit register.
- Increments when m0_req & ~m0_gnt.
- Clears when m0_gnt or ~m0_req.
- Saturates at MAX_WAIT.

Read return:
- Registered rd_own, one of IDLE, M0, M1.
- Set to M0 on m0_gnt & ~m0_we, to M1 on m1_gnt, otherwise IDLE.
- Next cycle, mN_rvalid = (rd_own==MN), and mN_rdata = ram_rdata when valid, else 0.
- Writes produce no rvalid.
- Latency: grant cycle T, data cycle T+1.
- Back-to-back grants to alternating masters are allowed every cycle; rvalid alternates accordingly.

Reset (reset==0 at a clk edge):
- wait_cnt=0, rd_own=IDLE, last_gnt=M1.
- All outputs 0 while reset is low.
- A read granted in the cycle reset asserts gets no rvalid.

Boundaries:
- Requests arriving in the first cycle after reset release are arbitrated normally.
- Simultaneous m0 write and m1 read with m0 starved: the write proceeds and m1 is denied.
- MAX_WAIT=1: m0 is never denied two cycles in a row.

Optional Feature:
SOC_DMEM_ARB_RR_EN
- Defined: round-robin replaces fixed priority when both request.
  - The winner is the master not in last_gnt.
  - last_gnt updates on every grant.
  - wait_cnt/MAX_WAIT logic is removed.
- Undefined: fixed m1 priority with the MAX_WAIT starvation guard. last_gnt is unused and may be removed.

Test Plan:
1. Reset low 3 cycles with both req high -> all gnt, rvalid and ram_en = 0. After release, next cycle m1_gnt=1.
2. m0 read addr 0x00000010 alone, RAM word 4 = 0x12345678 -> m0_gnt at T, ram_addr=4. At T+1 m0_rvalid=1, m0_rdata=0x12345678, m1_rvalid=0.
3. m0 write addr 0x00000008, data 0xffffffaa, mask 0xf -> ram_we=1, ram_addr=2, no m0_rvalid. A following m0 read of 0x8 returns 0xffffffaa.
4. m1_req held high continuously, m0 read pending, MAX_WAIT=4 (fixed priority) -> m1 granted 4 cycles, m0 granted on the 5th. wait_cnt returns to 0 and m1 resumes the next cycle.
5. Both req continuous with SOC_DMEM_ARB_RR_EN -> grants alternate m0, m1, m0, ... starting with m0 after reset. rvalid alternates one cycle later with correct rdata per master.
6. m1 grant in cycle T with reset asserted in T+1 -> m1_rvalid stays 0. Arbiter resumes cleanly after release.

Source files
------------

// File: rtl/soc_dmem_arb_if.sv
// Bus bundle between the CPU port (m0), the VGA fetcher (m1) and the data RAM.
// The slave modport is the arbiter's view; the master modport is the driving side.
interface soc_dmem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic [DW/8-1:0]   m0_wmask;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic [AW-1:0]     m1_addr;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DW-1:0]     m1_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [AW-3:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW/8-1:0]   ram_wmask;
    logic [DW-1:0]     ram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
        output ram_rdata
    );
endinterface

// File: rtl/soc_dmem_arb.sv
// Two-master data RAM arbiter: fixed m1 priority with an m0 starvation guard,
// or round-robin when SOC_DMEM_ARB_RR_EN is defined.
//
// rd_own state | meaning
// OWN_IDLE     | no read data due this cycle
// OWN_M0       | RAM read data this cycle belongs to m0
// OWN_M1       | RAM read data this cycle belongs to m1
module soc_dmem_arb #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    soc_dmem_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_t;

    own_t r_rd_own;
    logic w_m0_win;
    logic w_m0_gnt;
    logic w_m1_gnt;
    logic w_m0_rvalid;
    logic w_m1_rvalid;
    logic w_unused;

`ifdef SOC_DMEM_ARB_RR_EN
    // r_last_m1 = 1 means the last grant went to m1 (reset value)
    logic r_last_m1;

    assign w_m0_win = r_last_m1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_m1 <= 1'b1;
        end else if (w_m0_gnt) begin
            r_last_m1 <= 1'b0;
        end else if (w_m1_gnt) begin
            r_last_m1 <= 1'b1;
        end
    end

    assign w_unused = ^{bus.m0_addr[1:0], bus.m1_addr[1:0], 4'(MAX_WAIT)};
`else
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;

    assign w_m0_win = (r_wait_cnt == LP_MAX_WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
        end else if (bus.m0_req && !w_m0_gnt) begin
            if (r_wait_cnt < LP_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end

    assign w_unused = ^{bus.m0_addr[1:0], bus.m1_addr[1:0]};
`endif

    // Grants are forced low while reset is held so every output reads 0
    assign w_m0_gnt = reset & bus.m0_req & (~bus.m1_req | w_m0_win);
    assign w_m1_gnt = reset & bus.m1_req & ~w_m0_gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_own <= OWN_IDLE;
        end else if (w_m0_gnt && !bus.m0_we) begin
            r_rd_own <= OWN_M0;
        end else if (w_m1_gnt) begin
            r_rd_own <= OWN_M1;
        end else begin
            r_rd_own <= OWN_IDLE;
        end
    end

    assign bus.m0_gnt    = w_m0_gnt;
    assign bus.m1_gnt    = w_m1_gnt;

    assign bus.ram_en    = w_m0_gnt | w_m1_gnt;
    assign bus.ram_we    = w_m0_gnt & bus.m0_we;
    assign bus.ram_addr  = w_m0_gnt ? bus.m0_addr[AW-1:2] :
                           w_m1_gnt ? bus.m1_addr[AW-1:2] : '0;
    assign bus.ram_wdata = w_m0_gnt ? bus.m0_wdata : '0;
    assign bus.ram_wmask = w_m0_gnt ? bus.m0_wmask : '0;

    // A read granted just before reset asserts is dropped by this gating
    assign w_m0_rvalid   = reset & (r_rd_own == OWN_M0);
    assign w_m1_rvalid   = reset & (r_rd_own == OWN_M1);

    assign bus.m0_rvalid = w_m0_rvalid;
    assign bus.m1_rvalid = w_m1_rvalid;
    assign bus.m0_rdata  = w_m0_rvalid ? bus.ram_rdata : '0;
    assign bus.m1_rdata  = w_m1_rvalid ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_soc_dmem_arb.sv
// Bench for soc_dmem_arb: per-cycle vector table with a read-return scoreboard
// fed from a reference copy of the RAM contents.
module tb_soc_dmem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;

    soc_dmem_arb_if #(.AW(AW), .DW(DW)) bus ();

    soc_dmem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 4) return 32'h1234_5678;
        return {8'hC0, b, 8'h5A, ~b};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    end

    // RAM model: registered read, byte-masked write
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_wmask[b]) mem[bus.ram_addr[5:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                end
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr[5:0]];
            end
        end
    end

    typedef struct {
        logic        reset;
        logic        r0;
        logic        we0;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic [3:0]  wm0;
        logic        r1;
        logic [31:0] a1;
        logic        g0;
        logic        g1;
    } vec_t;

    typedef struct {
        logic        m;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int checks;
    int failures;

    function automatic vec_t v(input logic rst, input logic r0, input logic we0,
                               input logic [31:0] a0, input logic [31:0] wd0,
                               input logic [3:0] wm0, input logic r1,
                               input logic [31:0] a1, input logic g0, input logic g1);
        vec_t t;
        t.reset = rst; t.r0 = r0; t.we0 = we0; t.a0 = a0; t.wd0 = wd0;
        t.wm0 = wm0; t.r1 = r1; t.a1 = a1; t.g0 = g0; t.g1 = g1;
        return t;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int step);
        exp_t        e;
        logic        e_rv0, e_rv1;
        logic [31:0] e_d0, e_d1, e_addr, w;
        reset        = t.reset;
        bus.m0_req   = t.r0;
        bus.m0_we    = t.we0;
        bus.m0_addr  = t.a0;
        bus.m0_wdata = t.wd0;
        bus.m0_wmask = t.wm0;
        bus.m1_req   = t.r1;
        bus.m1_addr  = t.a1;
        @(negedge clk);

        e_rv0 = 1'b0; e_rv1 = 1'b0; e_d0 = '0; e_d1 = '0;
        if (t.reset && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m) begin e_rv1 = 1'b1; e_d1 = e.data; end
            else     begin e_rv0 = 1'b1; e_d0 = e.data; end
        end else begin
            sb.delete();
        end
        chk("m0_rvalid", step, 32'(bus.m0_rvalid), 32'(e_rv0));
        chk("m1_rvalid", step, 32'(bus.m1_rvalid), 32'(e_rv1));
        chk("m0_rdata",  step, bus.m0_rdata, e_d0);
        chk("m1_rdata",  step, bus.m1_rdata, e_d1);

        chk("m0_gnt", step, 32'(bus.m0_gnt), 32'(t.g0));
        chk("m1_gnt", step, 32'(bus.m1_gnt), 32'(t.g1));
        chk("ram_en", step, 32'(bus.ram_en), 32'(t.g0 | t.g1));
        chk("ram_we", step, 32'(bus.ram_we), 32'(t.g0 & t.we0));
        e_addr = t.g0 ? {2'b00, t.a0[31:2]} : t.g1 ? {2'b00, t.a1[31:2]} : 32'h0;
        chk("ram_addr", step, 32'(bus.ram_addr), e_addr);
        chk("ram_wmask", step, 32'(bus.ram_wmask), t.g0 ? 32'(t.wm0) : 32'h0);
        if (t.g0 && t.we0) chk("ram_wdata", step, bus.ram_wdata, t.wd0);

        if (t.g0 && !t.we0) begin
            e.m = 1'b0; e.data = ref_mem[t.a0[7:2]]; sb.push_back(e);
        end
        if (t.g0 && t.we0) begin
            w = ref_mem[t.a0[7:2]];
            for (int b = 0; b < 4; b++) if (t.wm0[b]) w[8*b +: 8] = t.wd0[8*b +: 8];
            ref_mem[t.a0[7:2]] = w;
        end
        if (t.g1) begin
            e.m = 1'b1; e.data = ref_mem[t.a1[7:2]]; sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

`ifdef SOC_DMEM_ARB_RR_EN
        for (int i = 0; i < 2; i++) vecs.push_back(v(0, 1,0,32'h10,0,0, 1,32'h40, 0,0));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h40, 1,0));
        vecs.push_back(v(1, 1,0,32'h14,0,0, 1,32'h40, 0,1));
        vecs.push_back(v(1, 1,0,32'h14,0,0, 1,32'h44, 1,0));
        vecs.push_back(v(1, 1,0,32'h18,0,0, 1,32'h44, 0,1));
        vecs.push_back(v(1, 1,0,32'h18,0,0, 1,32'h48, 1,0));
        vecs.push_back(v(1, 1,0,32'h1C,0,0, 0,32'h0,  1,0));
        vecs.push_back(v(1, 1,0,32'h20,0,0, 1,32'h48, 0,1));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h4C, 0,1));
        vecs.push_back(v(1, 1,0,32'h20,0,0, 1,32'h50, 1,0));
        vecs.push_back(v(1, 1,1,32'h24,32'h0BAD_F00D,4'hF, 1,32'h50, 0,1));
        vecs.push_back(v(1, 1,1,32'h24,32'h0BAD_F00D,4'hF, 1,32'h54, 1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h24, 0,1));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 0,32'h0,  0,0));
`else
        // reset with both requesting, then m1 wins MAX_WAIT times before m0 is forced
        for (int i = 0; i < 3; i++) vecs.push_back(v(0, 1,0,32'h10,0,0, 1,32'h40, 0,0));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h40, 0,1));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h44, 0,1));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h48, 0,1));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h4C, 0,1));
        vecs.push_back(v(1, 1,0,32'h10,0,0, 1,32'h50, 1,0));
        vecs.push_back(v(1, 1,0,32'h14,0,0, 1,32'h50, 0,1));
        vecs.push_back(v(1, 1,0,32'h14,0,0, 0,32'h0,  1,0));
        // lone m0 read, full write, read-back, idle, partial write, m1 read of it
        vecs.push_back(v(1, 1,0,32'h10,0,0, 0,32'h0, 1,0));
        vecs.push_back(v(1, 1,1,32'h08,32'hFFFF_FFAA,4'hF, 0,32'h0, 1,0));
        vecs.push_back(v(1, 1,0,32'h08,0,0, 0,32'h0, 1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 0,32'h0, 0,0));
        vecs.push_back(v(1, 1,1,32'h08,32'h0000_00BB,4'h1, 0,32'h0, 1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h08, 0,1));
        // starved m0 write against continuous m1 reads
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1, 1,1,32'h20,32'hDEAD_BEEF,4'hF, 1,32'h60 + 32'(4*i), 0,1));
        vecs.push_back(v(1, 1,1,32'h20,32'hDEAD_BEEF,4'hF, 1,32'h70, 1,0));
        // alternating lone masters every cycle
        vecs.push_back(v(1, 1,0,32'h20,0,0, 0,32'h0,  1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h70, 0,1));
        vecs.push_back(v(1, 1,0,32'h04,0,0, 0,32'h0,  1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h74, 0,1));
        // reset right after an m1 grant: that read must not return
        vecs.push_back(v(0, 1,0,32'h0, 0,0, 1,32'h78, 0,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 1,32'h7C, 0,1));
        vecs.push_back(v(1, 1,0,32'h00,0,0, 0,32'h0,  1,0));
        vecs.push_back(v(1, 0,0,32'h0, 0,0, 0,32'h0,  0,0));
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
